// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: per-axis raster timing description, total helper and standard modes
package vga_timing_pkg;
    typedef struct packed {
        int unsigned visible;
        int unsigned front;
        int unsigned sync;
        int unsigned back;
    } vga_axis_t;
    typedef struct packed {
        vga_axis_t h;
        vga_axis_t v;
    } vga_mode_t;
    function automatic int unsigned axis_total(vga_axis_t a);
        return a.visible + a.front + a.sync + a.back;
    endfunction
    localparam vga_mode_t VGA_640x480 = '{h: '{640, 16, 96, 48}, v: '{480, 10, 2, 33}};
    localparam vga_mode_t VGA_800x600 = '{h: '{800, 40, 128, 88}, v: '{600, 1, 4, 23}};
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis (count, registered sync, next-state active decode, wrap)
//   clk, rst (async, active high); step advances the count; restart forces the next count to 0
//   count: position on the axis; sync: registered sync level; active: next count is visible;
//   wrap: count sits on the last position
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter vga_axis_t AXIS = VGA_640x480.h,
    parameter logic      POL  = 1'b0,
    parameter int        W    = $clog2(axis_total(AXIS))
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step,
    input  logic         restart,
    output logic [W-1:0] count,
    output logic         sync,
    output logic         active,
    output logic         wrap
);
    localparam logic [W-1:0] LAST    = W'(axis_total(AXIS) - 1);
    localparam logic [W-1:0] VIS     = W'(AXIS.visible);
    localparam logic [W-1:0] SYNC_LO = W'(AXIS.visible + AXIS.front);
    localparam logic [W-1:0] SYNC_HI = W'(AXIS.visible + AXIS.front + AXIS.sync);
    if (AXIS.front == 0 || AXIS.sync == 0 || AXIS.back == 0) begin : g_bad_axis
        $fatal(1, "vga_axis_counter: porch and sync widths must be nonzero");
    end
    logic [W-1:0] count_q, count_d;
    logic         sync_q, sync_d;
    assign wrap = count_q == LAST;
    // Sync is decoded from the next count so it flips on the same edge as the count.
    always_comb begin
        count_d = restart ? '0 : !step ? count_q : wrap ? '0 : count_q + 1'b1;
        sync_d  = (count_d >= SYNC_LO && count_d < SYNC_HI) ? POL : !POL;
        active  = count_d < VIS;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= LAST;
            sync_q  <= !POL;
        end else begin
            count_q <= count_d;
            sync_q  <= sync_d;
        end
    end
    assign count = count_q;
    assign sync  = sync_q;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator advancing on a pixel-rate enable
//   clk, rst (async, active high), pix_en (pixel tick), restart (next tick lands on (0,0))
//   h_count/v_count: raster position; hsync/vsync: polarity-configured syncs;
//   video_active: visible region; line_end/frame_end: last pixel of line/frame;
//   frame_start: one-clk pulse on entry to (0,0); frame_cnt: completed frames
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int FCNT_W    = 8,
    localparam int HW = $clog2(H_VISIBLE + H_FRONT + H_SYNC + H_BACK),
    localparam int VW = $clog2(V_VISIBLE + V_FRONT + V_SYNC + V_BACK)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_en,
    input  logic              restart,
    output logic [HW-1:0]     h_count,
    output logic [VW-1:0]     v_count,
    output logic              hsync,
    output logic              vsync,
    output logic              video_active,
    output logic              line_end,
    output logic              frame_end,
    output logic              frame_start,
    output logic [FCNT_W-1:0] frame_cnt
);
    localparam vga_axis_t H_AXIS = '{H_VISIBLE, H_FRONT, H_SYNC, H_BACK};
    localparam vga_axis_t V_AXIS = '{V_VISIBLE, V_FRONT, V_SYNC, V_BACK};
    logic              h_wrap, v_wrap, h_act, v_act, go;
    logic              pend_q, pend_d, first_q, first_d, fs_q, fs_d, va_q, va_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    vga_axis_counter #(.AXIS(H_AXIS), .POL(HSYNC_POL != 0)) u_h (
        .clk, .rst, .step(pix_en), .restart(go),
        .count(h_count), .sync(hsync), .active(h_act), .wrap(h_wrap)
    );
    vga_axis_counter #(.AXIS(V_AXIS), .POL(VSYNC_POL != 0)) u_v (
        .clk, .rst, .step(pix_en && h_wrap), .restart(go),
        .count(v_count), .sync(vsync), .active(v_act), .wrap(v_wrap)
    );
    // A restart seen without a tick waits in pend_q; first_q keeps the reset-to-(0,0) entry from counting as a frame.
    always_comb begin
        go      = pix_en && (restart || pend_q);
        pend_d  = pix_en ? 1'b0 : pend_q || restart;
        first_d = first_q && !pix_en;
        fs_d    = pix_en && (go || (h_wrap && v_wrap));
        va_d    = h_act && v_act;
        fcnt_d  = (pix_en && h_wrap && v_wrap && !go && !first_q) ? fcnt_q + 1'b1 : fcnt_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q  <= 1'b0;
            first_q <= 1'b1;
            fs_q    <= 1'b0;
            va_q    <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            pend_q  <= pend_d;
            first_q <= first_d;
            fs_q    <= fs_d;
            va_q    <= va_d;
            fcnt_q  <= fcnt_d;
        end
    end
    assign video_active = va_q;
    assign line_end     = h_wrap;
    assign frame_end    = h_wrap && v_wrap;
    assign frame_start  = fs_q;
    assign frame_cnt    = fcnt_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized and directed checks of three raster configurations against a linear-position model
module tb_vga_timing_gen;
    typedef struct {
        int hv, hf, hs, hb, vv, vf, vs, vb, hp, vp, fw;
    } cfg_t;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;
    logic en [3];
    logic rs [3];
    logic hs_o [3], vs_o [3], va_o [3], le_o [3], fe_o [3], fs_o [3];
    logic [9:0] def_h, def_v;
    logic [7:0] def_fc;
    logic [2:0] tin_h, tin_v;
    logic [7:0] tin_fc;
    logic [4:0] med_h;
    logic [3:0] med_v;
    logic [2:0] med_fc;
    logic [53:0] obs [3];
    cfg_t cfg [3];
    int mpos [3], mfc [3];
    bit mpend [3], mfirst [3], mfs [3];
    int checks = 0, fails = 0;

    vga_timing_gen u_def (
        .clk(clk), .rst(rst), .pix_en(en[0]), .restart(rs[0]),
        .h_count(def_h), .v_count(def_v), .hsync(hs_o[0]), .vsync(vs_o[0]),
        .video_active(va_o[0]), .line_end(le_o[0]), .frame_end(fe_o[0]),
        .frame_start(fs_o[0]), .frame_cnt(def_fc)
    );
    vga_timing_gen #(
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
        .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HSYNC_POL(1), .VSYNC_POL(1)
    ) u_tin (
        .clk(clk), .rst(rst), .pix_en(en[1]), .restart(rs[1]),
        .h_count(tin_h), .v_count(tin_v), .hsync(hs_o[1]), .vsync(vs_o[1]),
        .video_active(va_o[1]), .line_end(le_o[1]), .frame_end(fe_o[1]),
        .frame_start(fs_o[1]), .frame_cnt(tin_fc)
    );
    vga_timing_gen #(
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .FCNT_W(3)
    ) u_med (
        .clk(clk), .rst(rst), .pix_en(en[2]), .restart(rs[2]),
        .h_count(med_h), .v_count(med_v), .hsync(hs_o[2]), .vsync(vs_o[2]),
        .video_active(va_o[2]), .line_end(le_o[2]), .frame_end(fe_o[2]),
        .frame_start(fs_o[2]), .frame_cnt(med_fc)
    );

    assign obs[0] = {16'(def_h), 16'(def_v), 16'(def_fc), hs_o[0], vs_o[0], va_o[0], le_o[0], fe_o[0], fs_o[0]};
    assign obs[1] = {16'(tin_h), 16'(tin_v), 16'(tin_fc), hs_o[1], vs_o[1], va_o[1], le_o[1], fe_o[1], fs_o[1]};
    assign obs[2] = {16'(med_h), 16'(med_v), 16'(med_fc), hs_o[2], vs_o[2], va_o[2], le_o[2], fe_o[2], fs_o[2]};

    function automatic int htot(int i);
        return cfg[i].hv + cfg[i].hf + cfg[i].hs + cfg[i].hb;
    endfunction
    function automatic int ftot(int i);
        return htot(i) * (cfg[i].vv + cfg[i].vf + cfg[i].vs + cfg[i].vb);
    endfunction
    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            mpos[i] = ftot(i) - 1;
            mfc[i] = 0;
            mpend[i] = 0;
            mfirst[i] = 1;
            mfs[i] = 0;
        end
    endfunction
    // The raster is a single linear pixel index per frame; h and v are derived from it.
    function automatic void model_tick(int i, bit e, bit r);
        bit wrap, go;
        if (!e) begin
            mpend[i] = mpend[i] || r;
            mfs[i] = 0;
            return;
        end
        wrap = mpos[i] == ftot(i) - 1;
        go = r || mpend[i];
        mfs[i] = wrap || go;
        if (wrap && !go && !mfirst[i]) mfc[i] = (mfc[i] + 1) % (1 << cfg[i].fw);
        mpos[i] = (wrap || go) ? 0 : mpos[i] + 1;
        mpend[i] = 0;
        mfirst[i] = 0;
    endfunction
    function automatic logic [53:0] exp_vec(int i);
        int ht, h, v, vt;
        logic ehs, evs, eva, ele, efe;
        ht = htot(i);
        vt = ftot(i) / ht;
        h = mpos[i] % ht;
        v = mpos[i] / ht;
        ehs = (h >= cfg[i].hv + cfg[i].hf && h < cfg[i].hv + cfg[i].hf + cfg[i].hs) ? cfg[i].hp != 0 : cfg[i].hp == 0;
        evs = (v >= cfg[i].vv + cfg[i].vf && v < cfg[i].vv + cfg[i].vf + cfg[i].vs) ? cfg[i].vp != 0 : cfg[i].vp == 0;
        eva = h < cfg[i].hv && v < cfg[i].vv;
        ele = h == ht - 1;
        efe = ele && v == vt - 1;
        return {16'(h), 16'(v), 16'(mfc[i]), ehs, evs, eva, ele, efe, mfs[i]};
    endfunction

    task automatic cycle(int i, bit e, bit r);
        en[i] = e;
        rs[i] = r;
        @(posedge clk);
        model_tick(i, e, r);
        @(negedge clk);
        en[i] = 1'b0;
        rs[i] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            en[i] = 1'b0;
            rs[i] = 1'b0;
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs[i] !== exp_vec(i)) begin
                fails++;
                $display("FAIL reset inst=%0d got=%h want=%h", i, obs[i], exp_vec(i));
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_tiny_raster();
        int hs_hi = 0, vs_hi = 0, va_hi = 0;
        for (int k = 0; k < 84; k++) begin
            cycle(1, 1'b1, 1'b0);
            checks++;
            if (obs[1] !== exp_vec(1)) begin
                fails++;
                $display("FAIL tiny_tick k=%0d got=%h want=%h", k, obs[1], exp_vec(1));
            end
            if (k < 42) begin
                hs_hi += int'(hs_o[1]);
                vs_hi += int'(vs_o[1]);
                va_hi += int'(va_o[1]);
            end
        end
        checks += 3;
        if (hs_hi !== 6) begin fails++; $display("FAIL tiny_hsync_count got=%0d want=6", hs_hi); end
        if (vs_hi !== 7) begin fails++; $display("FAIL tiny_vsync_count got=%0d want=7", vs_hi); end
        if (va_hi !== 12) begin fails++; $display("FAIL tiny_active_count got=%0d want=12", va_hi); end
    endtask

    task automatic test_default_raster();
        int hs_lo = 0, va_hi = 0;
        for (int k = 0; k <= 45 * 800 + 123; k++) begin
            cycle(0, 1'b1, 1'b0);
            checks++;
            if (obs[0] !== exp_vec(0)) begin
                fails++;
                $display("FAIL default_tick k=%0d got=%h want=%h", k, obs[0], exp_vec(0));
            end
            if (k < 800) begin
                hs_lo += int'(!hs_o[0]);
                va_hi += int'(va_o[0]);
            end
        end
        checks += 3;
        if (hs_lo !== 96) begin fails++; $display("FAIL default_hsync_low got=%0d want=96", hs_lo); end
        if (va_hi !== 640) begin fails++; $display("FAIL default_active_line got=%0d want=640", va_hi); end
        if (def_h !== 10'd123 || def_v !== 10'd45) begin
            fails++;
            $display("FAIL default_position got=(%0d,%0d) want=(123,45)", def_h, def_v);
        end
        cycle(0, 1'b0, 1'b1);
        cycle(0, 1'b0, 1'b0);
        checks++;
        if (obs[0] !== exp_vec(0)) begin fails++; $display("FAIL pending_hold got=%h want=%h", obs[0], exp_vec(0)); end
        cycle(0, 1'b1, 1'b0);
        checks++;
        if (def_h !== 10'd0 || def_v !== 10'd0 || fs_o[0] !== 1'b1 || def_fc !== 8'd0) begin
            fails++;
            $display("FAIL pending_apply got=(%0d,%0d,fs=%b,fc=%0d) want=(0,0,fs=1,fc=0)", def_h, def_v, fs_o[0], def_fc);
        end
        for (int k = 0; k < 300; k++) cycle(0, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs[i] !== exp_vec(i)) begin
                fails++;
                $display("FAIL async_reset inst=%0d got=%h want=%h", i, obs[i], exp_vec(i));
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_sparse_enable();
        for (int k = 0; k < 4 * 320; k++) begin
            cycle(2, k % 4 == 0, 1'b0);
            checks++;
            if (obs[2] !== exp_vec(2)) begin
                fails++;
                $display("FAIL sparse k=%0d got=%h want=%h", k, obs[2], exp_vec(2));
            end
        end
    endtask

    task automatic test_restart_on_wrap();
        int fc0;
        for (int k = 0; k < 400 && mpos[2] != ftot(2) - 1; k++) begin
            cycle(2, 1'b1, 1'b0);
            checks++;
            if (obs[2] !== exp_vec(2)) begin
                fails++;
                $display("FAIL seek_wrap k=%0d got=%h want=%h", k, obs[2], exp_vec(2));
            end
        end
        checks++;
        if (mpos[2] != ftot(2) - 1 || fe_o[2] !== 1'b1) begin
            fails++;
            $display("FAIL wrap_reached got=fe%b want=fe1", fe_o[2]);
        end
        fc0 = mfc[2];
        cycle(2, 1'b1, 1'b1);
        checks++;
        if (obs[2] !== exp_vec(2) || int'(med_fc) !== fc0 || fs_o[2] !== 1'b1) begin
            fails++;
            $display("FAIL restart_on_wrap got=%h want=%h", obs[2], exp_vec(2));
        end
    endtask

    task automatic test_random();
        bit e, r;
        for (int k = 0; k < 6000; k++) begin
            e = $urandom_range(0, 2) != 0;
            r = $urandom_range(0, 40) == 0;
            cycle(2, e, r);
            checks++;
            if (obs[2] !== exp_vec(2)) begin
                fails++;
                $display("FAIL random k=%0d got=%h want=%h", k, obs[2], exp_vec(2));
            end
        end
    endtask

    task automatic test_back_to_back();
        bit pat [6] = '{1, 1, 0, 1, 0, 1};
        bit rpat [6] = '{1, 1, 1, 0, 1, 1};
        for (int k = 0; k < 6; k++) begin
            cycle(2, pat[k], rpat[k]);
            checks++;
            if (obs[2] !== exp_vec(2)) begin
                fails++;
                $display("FAIL back_to_back k=%0d got=%h want=%h", k, obs[2], exp_vec(2));
            end
        end
    endtask

    initial begin
        cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 8};
        cfg[1] = '{4, 1, 1, 1, 3, 1, 1, 1, 1, 1, 8};
        cfg[2] = '{16, 2, 3, 2, 6, 2, 2, 3, 0, 0, 3};
        test_reset();
        test_tiny_raster();
        test_default_raster();
        test_sparse_enable();
        test_restart_on_wrap();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
